// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory and fills the IF/ID
// register through a valid/ready handshake, with branch redirect and fault trapping.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned PC_STEP    = 4,
    parameter int unsigned IMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] Read_address,
    input  logic [31:0] instruction_in,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        id_ready,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic        load;
    logic        handshake;
    logic        out_of_range;
    logic        target_misaligned;

    assign load              = !if_id_valid || id_ready;
    assign handshake         = if_id_valid && id_ready;
    assign out_of_range      = {2'b00, pc[31:2]} >= 32'(IMEM_DEPTH);
    assign target_misaligned = branch_target[1:0] != 2'b00;

    assign Read_address = pc;
    assign fetch_fault  = (state == FAULT);

    // Redirect beats the range check, which beats a normal load; a handshake
    // still counts in the same cycle a redirect or fault squashes IF/ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_instr <= 32'h0;
            if_id_pc    <= 32'h0;
            fetch_count <= 32'h0;
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (handshake) begin
                        fetch_count <= fetch_count + 32'd1;
                    end
                    if (branch_taken) begin
                        pc          <= branch_target;
                        if_id_valid <= 1'b0;
                        if (target_misaligned) begin
                            state <= FAULT;
                        end
                    end else if (out_of_range) begin
                        state       <= FAULT;
                        if_id_valid <= 1'b0;
                    end else if (load) begin
                        if_id_instr <= instruction_in;
                        if_id_pc    <= pc;
                        if_id_valid <= 1'b1;
                        pc          <= pc + 32'(PC_STEP);
                    end
                end
                FAULT: begin
                    if_id_valid <= 1'b0;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit; memory word k holds 0x1000+k.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] Read_address;
    logic [31:0] instruction_in;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_ready;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int total;
    int bad;

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .PC_STEP   (4),
        .IMEM_DEPTH(64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Read_address  (Read_address),
        .instruction_in(instruction_in),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .id_ready      (id_ready),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .fetch_fault   (fetch_fault),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory stand-in: word k holds 0x1000 + k.
    assign instruction_in = 32'h1000 + {2'b00, Read_address[31:2]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        id_ready = 1'b1;
        tick();
        tick();
        total++;
        if (if_id_valid !== 1'b0 || fetch_fault !== 1'b0 || fetch_count !== 32'h0 ||
            Read_address !== 32'h0 || if_id_pc !== 32'h0 || if_id_instr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_state: valid=%b fault=%b count=%0d addr=%h pc=%h instr=%h, required 0 0 0 0 0 0",
                     if_id_valid, fetch_fault, fetch_count, Read_address, if_id_pc, if_id_instr);
        end
        rst = 1'b0;
        tick();
        total++;
        if (if_id_valid !== 1'b0 || Read_address !== 32'h0) begin
            bad++;
            $display("[TB] FAIL boot_cycle: valid=%b addr=%h, required valid=0 addr=00000000",
                     if_id_valid, Read_address);
        end
    endtask

    task automatic test_sequential();
        id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * k) || if_id_instr !== 32'(32'h1000 + k) ||
                Read_address !== 32'(4 * k + 4) || fetch_count !== 32'(k)) begin
                bad++;
                $display("[TB] FAIL seq_fetch_%0d: valid=%b pc=%h instr=%h addr=%h count=%0d, required 1 %h %h %h %0d",
                         k, if_id_valid, if_id_pc, if_id_instr, Read_address, fetch_count,
                         32'(4 * k), 32'(32'h1000 + k), 32'(4 * k + 4), k);
            end
        end
    endtask

    task automatic test_backpressure();
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || if_id_instr !== 32'h1002 ||
                Read_address !== 32'hC || fetch_count !== 32'd2) begin
                bad++;
                $display("[TB] FAIL stall_%0d: valid=%b pc=%h instr=%h addr=%h count=%0d, required 1 00000008 00001002 0000000c 2",
                         k, if_id_valid, if_id_pc, if_id_instr, Read_address, fetch_count);
            end
        end
        id_ready = 1'b1;
        tick();
        total++;
        if (if_id_pc !== 32'hC || if_id_instr !== 32'h1003 || Read_address !== 32'h10 || fetch_count !== 32'd3) begin
            bad++;
            $display("[TB] FAIL stall_release: pc=%h instr=%h addr=%h count=%0d, required 0000000c 00001003 00000010 3",
                     if_id_pc, if_id_instr, Read_address, fetch_count);
        end
        tick();
        total++;
        if (if_id_pc !== 32'h10 || if_id_instr !== 32'h1004 || fetch_count !== 32'd4) begin
            bad++;
            $display("[TB] FAIL post_stall: pc=%h instr=%h count=%0d, required 00000010 00001004 4",
                     if_id_pc, if_id_instr, fetch_count);
        end
    endtask

    task automatic test_branch();
        id_ready = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h20;
        tick();
        branch_taken = 1'b0;
        total++;
        if (if_id_valid !== 1'b0 || Read_address !== 32'h20 || fetch_count !== 32'd4) begin
            bad++;
            $display("[TB] FAIL branch_bubble: valid=%b addr=%h count=%0d, required 0 00000020 4",
                     if_id_valid, Read_address, fetch_count);
        end
        id_ready = 1'b1;
        tick();
        total++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h20 || if_id_instr !== 32'h1008 || Read_address !== 32'h24) begin
            bad++;
            $display("[TB] FAIL branch_target: valid=%b pc=%h instr=%h addr=%h, required 1 00000020 00001008 00000024",
                     if_id_valid, if_id_pc, if_id_instr, Read_address);
        end
    endtask

    task automatic test_back_to_back();
        id_ready = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        total++;
        if (if_id_valid !== 1'b0 || Read_address !== 32'h40 || fetch_count !== 32'd5) begin
            bad++;
            $display("[TB] FAIL branch_with_handshake: valid=%b addr=%h count=%0d, required 0 00000040 5",
                     if_id_valid, Read_address, fetch_count);
        end
        tick();
        total++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h40 || if_id_instr !== 32'h1010 || fetch_count !== 32'd5) begin
            bad++;
            $display("[TB] FAIL branch_with_handshake_target: valid=%b pc=%h instr=%h count=%0d, required 1 00000040 00001010 5",
                     if_id_valid, if_id_pc, if_id_instr, fetch_count);
        end
    endtask

    task automatic test_misaligned();
        id_ready = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h22;
        tick();
        total++;
        if (fetch_fault !== 1'b1 || if_id_valid !== 1'b0 || Read_address !== 32'h22 || fetch_count !== 32'd6) begin
            bad++;
            $display("[TB] FAIL misaligned_fault: fault=%b valid=%b addr=%h count=%0d, required 1 0 00000022 6",
                     fetch_fault, if_id_valid, Read_address, fetch_count);
        end
        branch_target = 32'h0;
        tick();
        branch_taken = 1'b0;
        tick();
        total++;
        if (fetch_fault !== 1'b1 || if_id_valid !== 1'b0 || Read_address !== 32'h22 || fetch_count !== 32'd6) begin
            bad++;
            $display("[TB] FAIL fault_sticky: fault=%b valid=%b addr=%h count=%0d, required 1 0 00000022 6",
                     fetch_fault, if_id_valid, Read_address, fetch_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (fetch_fault !== 1'b0 || Read_address !== 32'h0 || if_id_valid !== 1'b0 || fetch_count !== 32'h0) begin
            bad++;
            $display("[TB] FAIL fault_cleared: fault=%b addr=%h valid=%b count=%0d, required 0 00000000 0 0",
                     fetch_fault, Read_address, if_id_valid, fetch_count);
        end
    endtask

    task automatic test_range();
        id_ready = 1'b1;
        tick();
        for (int k = 0; k < 64; k++) begin
            tick();
        end
        total++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'hFC || if_id_instr !== 32'h103F ||
            Read_address !== 32'h100 || fetch_count !== 32'd63 || fetch_fault !== 1'b0) begin
            bad++;
            $display("[TB] FAIL range_last_word: valid=%b pc=%h instr=%h addr=%h count=%0d fault=%b, required 1 000000fc 0000103f 00000100 63 0",
                     if_id_valid, if_id_pc, if_id_instr, Read_address, fetch_count, fetch_fault);
        end
        tick();
        total++;
        if (fetch_fault !== 1'b1 || if_id_valid !== 1'b0 || Read_address !== 32'h100 || fetch_count !== 32'd64) begin
            bad++;
            $display("[TB] FAIL range_fault: fault=%b valid=%b addr=%h count=%0d, required 1 0 00000100 64",
                     fetch_fault, if_id_valid, Read_address, fetch_count);
        end
        tick();
        total++;
        if (fetch_fault !== 1'b1 || Read_address !== 32'h100 || fetch_count !== 32'd64) begin
            bad++;
            $display("[TB] FAIL range_hold: fault=%b addr=%h count=%0d, required 1 00000100 64",
                     fetch_fault, Read_address, fetch_count);
        end
    endtask

    task automatic test_reset_mid_stall();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        id_ready = 1'b1;
        tick();
        tick();
        tick();
        id_ready = 1'b0;
        tick();
        total++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h4 || fetch_count !== 32'd1) begin
            bad++;
            $display("[TB] FAIL pre_reset_stall: valid=%b pc=%h count=%0d, required 1 00000004 1",
                     if_id_valid, if_id_pc, fetch_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || if_id_instr !== 32'h0 || Read_address !== 32'h0 ||
            fetch_count !== 32'h0 || fetch_fault !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_stall: valid=%b pc=%h instr=%h addr=%h count=%0d fault=%b, required 0 0 0 0 0 0",
                     if_id_valid, if_id_pc, if_id_instr, Read_address, fetch_count, fetch_fault);
        end
        id_ready = 1'b1;
        tick();
        total++;
        if (if_id_valid !== 1'b0 || Read_address !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reboot_cycle: valid=%b addr=%h, required 0 00000000", if_id_valid, Read_address);
        end
        tick();
        total++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr !== 32'h1000) begin
            bad++;
            $display("[TB] FAIL reboot_first_fetch: valid=%b pc=%h instr=%h, required 1 00000000 00001000",
                     if_id_valid, if_id_pc, if_id_instr);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch();
        test_back_to_back();
        test_misaligned();
        test_range();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
